// File: rtl/clk_div_bank_if.sv
// Control and output bundle for clk_div_bank.
// Latency: wires only, no storage.
// Backpressure: none; every write strobe is taken on the edge it is presented.
//
// Signals:
//   enable   global run, 0 freezes every channel
//   wr_en    half-period write strobe
//   wr_ch    target channel of the write
//   wr_half  new half-period value
//   sync     realign request (only acted on when the bank is built with CLK_DIV_SYNC_EN)
//   clk_out  divided square waves
//   tick     one-cycle pulse per clk_out toggle
//   rise     one-cycle pulse per clk_out 0->1
interface clk_div_bank_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 27
);
   logic              enable;
   logic              wr_en;
   logic [2:0]        wr_ch;
   logic [CNT_W-1:0]  wr_half;
   logic              sync;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] rise;

   // master drives the controls and watches the outputs
   modport master (
      output enable, wr_en, wr_ch, wr_half, sync,
      input  clk_out, tick, rise
   );

   // slave is the divider bank itself
   modport slave (
      input  enable, wr_en, wr_ch, wr_half, sync,
      output clk_out, tick, rise
   );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable square-wave dividers off clk_osc.
// Latency: clk_out/tick/rise update on the edge where the count hits the half-period.
// Backpressure: none; writes and sync always take effect on the next edge.
//
// Ports:
//   clk_osc    board oscillator, all logic on its rising edge
//   RESET      synchronous active-high reset, overrides everything
//   reset_out  unregistered copy of RESET for downstream blocks
//   bus        clk_div_bank_if slave: enable, write port, sync, clk_out/tick/rise
//
// Build option: define CLK_DIV_SYNC_EN to make sync clear every channel's
// phase (counter and clk_out) while keeping the programmed half-periods.
// Without it the sync input is left unconnected inside the bank.
module clk_div_bank #(
   parameter int          NUM_CH   = 4,
   parameter int          CNT_W    = 27,
   parameter int unsigned DEF_HALF = 24999999
) (
   input  logic          clk_osc,
   input  logic          RESET,
   output logic          reset_out,
   clk_div_bank_if.slave bus
);

   localparam logic [CNT_W-1:0] DEF_HALF_W = CNT_W'(DEF_HALF);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CNT_W-1:0]  hp_q  [NUM_CH];
   logic [CNT_W-1:0]  hp_d  [NUM_CH];
   logic [NUM_CH-1:0] clk_q, clk_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] rise_q, rise_d;
   logic [NUM_CH-1:0] wr_hit;
   logic              sync_hit;

   assign reset_out = RESET;

`ifdef CLK_DIV_SYNC_EN
   assign sync_hit = bus.sync;
`else
   logic unused_sync;
   assign unused_sync = bus.sync;
   assign sync_hit    = 1'b0;
`endif

   // Channel indices at or above NUM_CH never match, so such writes drop out.
   always_comb begin
      wr_hit = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         wr_hit[c] = bus.wr_en && (bus.wr_ch == 3'(c));
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_d[c]  = cnt_q[c];
         hp_d[c]   = hp_q[c];
         clk_d[c]  = clk_q[c];
         tick_d[c] = 1'b0;
         rise_d[c] = 1'b0;

         if (wr_hit[c]) begin
            // A write restarts the channel in its low phase; it beats a
            // terminal count on the same edge, so no tick escapes.
            hp_d[c]  = bus.wr_half;
            cnt_d[c] = '0;
            clk_d[c] = 1'b0;
         end else if (sync_hit) begin
            cnt_d[c] = '0;
            clk_d[c] = 1'b0;
         end else if (bus.enable) begin
            if (cnt_q[c] == hp_q[c]) begin
               cnt_d[c]  = '0;
               clk_d[c]  = ~clk_q[c];
               tick_d[c] = 1'b1;
               rise_d[c] = ~clk_q[c];
            end else begin
               cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_osc) begin
      if (RESET) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= '0;
            hp_q[c]  <= DEF_HALF_W;
         end
         clk_q  <= '0;
         tick_q <= '0;
         rise_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= cnt_d[c];
            hp_q[c]  <= hp_d[c];
         end
         clk_q  <= clk_d;
         tick_q <= tick_d;
         rise_q <= rise_d;
      end
   end

   assign bus.clk_out = clk_q;
   assign bus.tick    = tick_q;
   assign bus.rise    = rise_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with NUM_CH=4, CNT_W=8, DEF_HALF=3.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is applied between edges.
module tb_clk_div_bank;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   logic clk;
   logic rst;
   logic rst_out;
   int   checks;
   int   errors;

   clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   clk_div_bank #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEF_HALF(3)
   ) dut (
      .clk_osc  (clk),
      .RESET    (rst),
      .reset_out(rst_out),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.enable  = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_ch   = 3'd0;
      bus.wr_half = '0;
      bus.sync    = 1'b0;
   endtask

   // Reset for one edge; afterwards every channel sits at cnt=0, hp=3.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Expected {clk_out, tick, rise} for a channel that restarted from cnt=0,
   // clk_out=0 on edge `start` with half-period hp, observed after edge n.
   function automatic logic [2:0] ref_ch(int n, int start, int hp);
      int   k;
      logic c;
      logic t;
      k = n - start;
      c = ((k / (hp + 1)) % 2) == 1;
      t = (k > 0) && ((k % (hp + 1)) == 0);
      return {c, t, t & c};
   endfunction

   task automatic test_reset();
      logic [3:0] ec, et, er;
      idle_inputs();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({bus.clk_out, bus.tick, bus.rise, rst_out} !== {12'h000, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got clk=%b tick=%b rise=%b rst_out=%b exp 0/0/0/1",
                     i, bus.clk_out, bus.tick, bus.rise, rst_out);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (rst_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_release got %b exp 0", rst_out);
      end
      for (int n = 1; n <= 8; n++) begin
         step();
         ec = (n >= 4 && n < 8) ? 4'hF : 4'h0;
         et = (n == 4 || n == 8) ? 4'hF : 4'h0;
         er = (n == 4) ? 4'hF : 4'h0;
         checks++;
         if ({bus.clk_out, bus.tick, bus.rise} !== {ec, et, er}) begin
            errors++;
            $display("FAIL reset_default_rate n=%0d got clk=%b tick=%b rise=%b exp clk=%b tick=%b rise=%b",
                     n, bus.clk_out, bus.tick, bus.rise, ec, et, er);
         end
      end
   endtask

   task automatic test_programming();
      logic [2:0] e0, e1, e2, e3;
      logic [3:0] ec, et, er;
      do_reset();
      bus.wr_en = 1'b1; bus.wr_ch = 3'd1; bus.wr_half = 8'd0;
      step();                                    // edge 1: ch1 hp=0
      bus.wr_ch = 3'd2; bus.wr_half = 8'd5;
      step();                                    // edge 2: ch2 hp=5
      bus.wr_en = 1'b0;
      for (int n = 2; n <= 22; n++) begin
         if (n > 2) step();
         e0 = ref_ch(n, 0, 3);
         e1 = ref_ch(n, 1, 0);
         e2 = ref_ch(n, 2, 5);
         e3 = ref_ch(n, 0, 3);
         ec = {e3[2], e2[2], e1[2], e0[2]};
         et = {e3[1], e2[1], e1[1], e0[1]};
         er = {e3[0], e2[0], e1[0], e0[0]};
         checks++;
         if ({bus.clk_out, bus.tick, bus.rise} !== {ec, et, er}) begin
            errors++;
            $display("FAIL programming n=%0d got clk=%b tick=%b rise=%b exp clk=%b tick=%b rise=%b",
                     n, bus.clk_out, bus.tick, bus.rise, ec, et, er);
         end
      end
   endtask

   task automatic test_write_at_terminal();
      logic [3:0] ec, et;
      do_reset();
      step(); step(); step();                    // cnt = 3 = hp on every channel
      bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_half = 8'd7;
      step();                                    // edge 4: ch0 write vs terminal count
      bus.wr_en = 1'b0;
      checks++;
      if ({bus.clk_out, bus.tick, bus.rise} !== {4'b1110, 4'b1110, 4'b1110}) begin
         errors++;
         $display("FAIL write_at_tc got clk=%b tick=%b rise=%b exp clk=1110 tick=1110 rise=1110",
                  bus.clk_out, bus.tick, bus.rise);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         ec = {3'b111, k == 8};
         et = {3'b000, k == 8};
         checks++;
         if ({bus.clk_out[0], bus.tick[0]} !== {ec[0], et[0]}) begin
            errors++;
            $display("FAIL write_at_tc_ch0 k=%0d got clk0=%b tick0=%b exp clk0=%b tick0=%b",
                     k, bus.clk_out[0], bus.tick[0], ec[0], et[0]);
         end
      end
   endtask

   task automatic test_enable_gating();
      do_reset();
      for (int i = 0; i < 4; i++) step();        // edge 4: all toggle high
      bus.enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.wr_en = 1'b1; bus.wr_ch = 3'd6; bus.wr_half = 8'd0;
         end else begin
            bus.wr_en = 1'b0;
         end
         step();
         checks++;
         if ({bus.clk_out, bus.tick, bus.rise} !== {4'hF, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL enable_hold i=%0d got clk=%b tick=%b rise=%b exp clk=1111 tick=0000 rise=0000",
                     i, bus.clk_out, bus.tick, bus.rise);
         end
      end
      bus.wr_en  = 1'b0;
      bus.enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (k < 4) begin
            if ({bus.clk_out, bus.tick} !== {4'hF, 4'h0}) begin
               errors++;
               $display("FAIL enable_resume k=%0d got clk=%b tick=%b exp clk=1111 tick=0000",
                        k, bus.clk_out, bus.tick);
            end
         end else begin
            if ({bus.clk_out, bus.tick, bus.rise} !== {4'h0, 4'hF, 4'h0}) begin
               errors++;
               $display("FAIL enable_resume_toggle got clk=%b tick=%b rise=%b exp clk=0000 tick=1111 rise=0000",
                        bus.clk_out, bus.tick, bus.rise);
            end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_half = 8'd1;
      step();
      bus.wr_en = 1'b0;
      step(); step();                            // ch0 now high
      checks++;
      if (bus.clk_out[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_setup got clk0=%b exp 1", bus.clk_out[0]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (rst_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_out_track got %b exp 1", rst_out);
      end
      step();
      rst = 1'b0;
      checks++;
      if ({bus.clk_out, bus.tick, bus.rise} !== 12'h000) begin
         errors++;
         $display("FAIL mid_reset_clear got clk=%b tick=%b rise=%b exp all 0",
                  bus.clk_out, bus.tick, bus.rise);
      end
      for (int n = 1; n <= 4; n++) begin
         step();
         checks++;
         if (bus.tick !== ((n == 4) ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL mid_reset_hp_default n=%0d got tick=%b exp %b",
                     n, bus.tick, (n == 4) ? 4'hF : 4'h0);
         end
      end
   endtask

   task automatic test_sync();
      logic [2:0] e0, e1, e2, e3;
      logic [3:0] ec, et, er;
      int s0, s1, s2;
      do_reset();
      bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_half = 8'd2;
      step();                                    // edge 1
      bus.wr_ch = 3'd1; bus.wr_half = 8'd4;
      step();                                    // edge 2
      bus.wr_en = 1'b0;
      step(); step();                            // edge 4: ch0 high, ch1 low
      bus.sync = 1'b1;
`ifdef CLK_DIV_SYNC_EN
      s0 = 5; s1 = 5; s2 = 5;
`else
      s0 = 1; s1 = 2; s2 = 0;
`endif
      for (int n = 5; n <= 21; n++) begin
         step();
         bus.sync = 1'b0;
         e0 = ref_ch(n, s0, 2);
         e1 = ref_ch(n, s1, 4);
         e2 = ref_ch(n, s2, 3);
         e3 = ref_ch(n, s2, 3);
         ec = {e3[2], e2[2], e1[2], e0[2]};
         et = {e3[1], e2[1], e1[1], e0[1]};
         er = {e3[0], e2[0], e1[0], e0[0]};
         checks++;
         if ({bus.clk_out, bus.tick, bus.rise} !== {ec, et, er}) begin
            errors++;
            $display("FAIL sync n=%0d got clk=%b tick=%b rise=%b exp clk=%b tick=%b rise=%b",
                     n, bus.clk_out, bus.tick, bus.rise, ec, et, er);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_programming();
      test_write_at_terminal();
      test_enable_gating();
      test_reset_mid_run();
      test_sync();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
